// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives a 1-bit ALU slice for WIDTH cycles, LSB first,
// keeping the ADD carry chain locally and assembling the WIDTH-bit result.
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             alu_a,
   output logic             alu_b,
   output logic [1:0]       alu_op,
   input  logic [2:0]       alu_y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int               CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
   localparam logic [1:0]       OP_ADD = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [1:0]       r_sop;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;

   logic             w_is_add;
   logic             w_rbit;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_last;
   logic             w_unused_y2;

   // The slice has no carry-in, so the carry is folded in here from its a^b / a&b outputs.
   assign w_is_add    = (r_sop == OP_ADD);
   assign w_rbit      = w_is_add ? (alu_y[0] ^ r_carry) : alu_y[0];
   assign w_carry_nxt = alu_y[1] | (alu_y[0] & r_carry);
   assign w_acc_nxt   = {w_rbit, r_acc[WIDTH-1:1]};
   assign w_last      = (r_cnt == LAST);
   assign w_unused_y2 = alu_y[2];

   assign result = r_result;
   assign cout   = r_cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      alu_a       = 1'b0;
      alu_b       = 1'b0;
      alu_op      = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy   = 1'b1;
            alu_a  = r_sa[0];
            alu_b  = r_sb[0];
            alu_op = r_sop;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_sop    <= 2'b00;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_sop   <= op;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
               r_acc   <= w_acc_nxt;
               r_cnt   <= r_cnt + CNT_W'(1);
               r_carry <= w_is_add & w_carry_nxt;
               if (w_last) begin
                  r_result <= w_acc_nxt;
                  r_cout   <= w_is_add & w_carry_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU slice model.
module tb_alu_serial_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             alu_a;
   logic             alu_b;
   logic [1:0]       alu_op;
   logic [2:0]       alu_y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   logic [WIDTH-1:0] prev_res;

   always #5 clk = ~clk;

   // Slice: logic ops on bit 0, ADD gives a+b in 0..2 on Y[1:0].
   always_comb begin
      case (alu_op)
         2'b00:   alu_y = {2'b00, alu_a & alu_b};
         2'b01:   alu_y = {2'b00, alu_a | alu_b};
         2'b10:   alu_y = {2'b00, alu_a ^ alu_b};
         default: alu_y = {1'b0, alu_a & alu_b, alu_a ^ alu_b};
      endcase
   end

   alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .op     (op),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_op (alu_op),
      .alu_y  (alu_y),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_drive(input string tag);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_op"}, alu_op, 0);
   endtask

   // Entered #1 after the accepting edge; leaves #1 after edge E(WIDTH).
   task automatic run_bits(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                           input logic [1:0] eop);
      for (int i = 0; i < WIDTH; i++) begin
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         chk("slice_a", alu_a, ea[i]);
         chk("slice_b", alu_b, eb[i]);
         chk("slice_op", alu_op, eop);
         chk("run_result_hold", result, prev_res);
         step();
      end
   endtask

   task automatic check_done(input logic [WIDTH-1:0] er, input logic ec);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_result", result, er);
      chk("done_cout", cout, ec);
      chk_idle_drive("done");
      prev_res = er;
   endtask

   task automatic do_op(input logic [1:0] top, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb_, input logic [WIDTH-1:0] er,
                        input logic ec);
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_;
      op    = top;
      step();
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      op    = 2'($urandom);
      run_bits(ta, tb_, top);
      check_done(er, ec);
      step();
      chk("post_done_low", done, 0);
      chk("post_busy_low", busy, 0);
      chk("post_result_held", result, er);
      chk("post_cout_held", cout, ec);
      chk_idle_drive("idle");
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      op       = 2'b00;
      prev_res = '0;

      // Reset and idle state
      step();
      step();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 8'h00);
      chk("rst_cout", cout, 0);
      chk_idle_drive("rst");
      step();
      step();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      // Reset beats a simultaneous start
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      op    = 2'b11;
      step();
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", busy, 0);
      step();
      chk("rst_start_busy2", busy, 0);
      chk("rst_start_done", done, 0);

      // ADD with wrap and carry-out, then a carry-free ADD
      do_op(2'b11, 8'hFF, 8'h01, 8'h00, 1'b1);
      do_op(2'b11, 8'h5A, 8'h23, 8'h7D, 1'b0);

      // Logic ops
      do_op(2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);
      do_op(2'b01, 8'h0F, 8'h80, 8'h8F, 1'b0);
      do_op(2'b10, 8'hAA, 8'hFF, 8'h55, 1'b0);

      // start held high through RUN and DONE with operands changing
      @(negedge clk);
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      op    = 2'b11;
      step();
      a = 8'hFF;
      b = 8'hFF;
      run_bits(8'h12, 8'h34, 2'b11);
      check_done(8'h46, 1'b0);
      step();
      chk("b2b_done_not_twice", done, 0);
      chk("b2b_idle_busy", busy, 0);
      step();
      start = 1'b0;
      run_bits(8'hFF, 8'hFF, 2'b11);
      check_done(8'hFE, 1'b1);
      step();
      chk("b2b_post_done", done, 0);
      chk("b2b_post_busy", busy, 0);

      // Reset in the middle of an ADD
      @(negedge clk);
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h23;
      op    = 2'b11;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid_busy", busy, 1);
      chk("mid_slice_a_bit4", alu_a, 1);
      chk("mid_slice_b_bit4", alu_b, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 8'h00);
      chk("abort_cout", cout, 0);
      chk_idle_drive("abort");
      prev_res = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_no_done", done, 0);
      end
      do_op(2'b11, 8'h80, 8'h81, 8'h01, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Sequencer that performs a WIDTH-bit operation by driving an external 1-bit ALU slice over WIDTH consecutive cycles, LSB first.
- The slice supports AND, OR, XOR and ADD, and returns a 3-bit Y.
- This block holds the operands, keeps the ADD carry chain (the slice has no carry-in), and assembles the result.
- Used wherever a wide ALU operation is needed but only one slice is instantiated.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
op  input  2  00 AND, 01 OR, 10 XOR, 11 ADD; sampled on accepted start
alu_a  output  1  bit to slice input a
alu_b  output  1  bit to slice input b
alu_op  output  2  opcode to slice
alu_y  input  3  slice result Y (combinational from alu_a/alu_b/alu_op)
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse, high in DONE
result  output  WIDTH  final result, valid from DONE onward, held until next DONE
cout  output  1  final ADD carry; 0 for logic ops; held with result

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; operand shift regs, carry, bit counter, result and cout all cleared. Outputs: busy=0, done=0, result=0, cout=0. Reset in any state, including mid-RUN, aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a, b and op into shift regs sa, sb and sop;
  - carry=0, cnt=0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: one bit processed per edge E1..E(WIDTH).
  - Slice drive is combinational: alu_a=sa[0], alu_b=sb[0], alu_op=sop.
  - Bit for AND/OR/XOR: rbit=alu_y[0].
  - Bit for ADD: rbit=alu_y[0]^carry; carry_next=alu_y[1] | (alu_y[0]&carry).
    - Slice ADD yields a+b in 0..2, so alu_y[1]=a&b and alu_y[0]=a^b.
    - alu_y[2] is ignored.
  - Each edge: sa and sb shift right (MSB filled with 0); rbit shifts into MSB of the internal accumulator acc; cnt++.
  - At the edge where cnt==WIDTH-1: go to DONE; result<=final acc (bit0 = first processed bit); cout<=carry_next if sop==ADD, else 0.
- Slice drive outside RUN: alu_a=0, alu_b=0, alu_op=00.
- DONE: done=1 and busy=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start accepted at E0 -> done high in the cycle after E(WIDTH), i.e. WIDTH+1 cycles after acceptance.
- Back-to-back throughput: one op per WIDTH+2 cycles. A new start is accepted only in IDLE, so the earliest re-accept is the edge after DONE.
- start while busy (RUN or DONE): ignored; no queuing, no effect on the in-flight op. Operands a/b/op may change freely after acceptance.
- result and cout: change only on entry to DONE or on reset, never during RUN.
- Simultaneous rst and start: reset wins.
- Arithmetic: ADD is unsigned modulo 2^WIDTH; carry-out is reported on cout; there is no overflow flag.

Test Plan:
1. WIDTH=8, rst for 2 cycles, then idle -> busy=0, done=0, result=0x00, cout=0, alu_op=00.
2. start with op=11, a=0xFF, b=0x01 -> done pulses exactly 9 cycles after acceptance; result=0x00, cout=1. Then op=11, a=0x5A, b=0x23 -> result=0x7D, cout=0.
3. Logic ops:
   - op=00, a=0xF0, b=0x3C -> 0x30;
   - op=01, a=0x0F, b=0x80 -> 0x8F;
   - op=10, a=0xAA, b=0xFF -> 0x55.
   - cout=0 for all three; result unchanged during RUN.
4. Busy handling: hold start=1 continuously with changing a/b during RUN and DONE -> first op completes with original operands; the next op is accepted on the edge after DONE; done never stays high for 2 consecutive cycles.
5. Reset mid-op: assert rst at bit 4 of an ADD -> next cycle IDLE, busy=0, result=0, cout=0, no done pulse. A fresh op afterwards completes correctly.
6. Slice protocol check: the monitor compares alu_a/alu_b against the expected operand bit each RUN cycle (LSB first) and checks alu_op equals the latched op. Outside RUN, all slice drives are 0.
